soc_miner_dma_ctrl: RTL and testbench

SOC_MINER_DMA_CTRL -- requirements
Module: soc_miner_dma_ctrl

---
 rtl/soc_miner_dma_ctrl_if.sv | 34 +++
 rtl/soc_miner_dma_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_soc_miner_dma_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_miner_dma_ctrl_if.sv
// soc_miner_dma_ctrl_if: register bus plus burst command channel
// between the copy engine (master) and its host/memory side (slave).
interface soc_miner_dma_ctrl_if #(
   parameter int ADDR_WIDTH      = 32,
   parameter int BURST_LEN_WIDTH = 4
);
   logic                       addr_valid;
   logic                       reg_write;
   logic [31:0]                reg_addr;
   logic [31:0]                reg_wdata;
   logic [31:0]                reg_rdata;
   logic                       reg_ready;
   logic                       cmd_valid;
   logic                       cmd_ready;
   logic [ADDR_WIDTH-1:0]      cmd_src;
   logic [ADDR_WIDTH-1:0]      cmd_dst;
   logic [BURST_LEN_WIDTH-1:0] cmd_len;
   logic [2:0]                 cmd_ch;
   logic                       cmd_done;

   modport master (
      input  addr_valid, reg_write, reg_addr, reg_wdata,
      output reg_rdata, reg_ready,
      output cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_ch,
      input  cmd_ready, cmd_done
   );

   modport slave (
      output addr_valid, reg_write, reg_addr, reg_wdata,
      input  reg_rdata, reg_ready,
      input  cmd_valid, cmd_src, cmd_dst, cmd_len, cmd_ch,
      output cmd_ready, cmd_done
   );
endinterface

// File: rtl/soc_miner_dma_ctrl.sv
// soc_miner_dma_ctrl: multi-channel copy engine; jobs are split into
// 4 KiB-safe bursts and channels are interleaved round-robin per burst.
module soc_miner_dma_ctrl #(
   parameter int NUM_CH          = 4,
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 32,
   parameter int BURST_LEN_WIDTH = 4
) (
   input  logic                 Clk,
   input  logic                 RESET,
   soc_miner_dma_ctrl_if.master bus,
   output logic                 irq
);
   localparam int BEAT_BYTES = DATA_WIDTH / 8;
   localparam int OFF        = $clog2(BEAT_BYTES);
   localparam int MAX_BEATS  = 1 << BURST_LEN_WIDTH;
   localparam logic [7:0] CH_MASK     = 8'((16'd1 << NUM_CH) - 16'd1);
   localparam logic [7:0] STATUS_ADDR = 8'(NUM_CH * 16);
   localparam logic [7:0] DONE_ADDR   = 8'(NUM_CH * 16 + 4);
   localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(BEAT_BYTES - 1);

   typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT} state_t;

   state_t                     state_q;
   logic                       req_q, req_wr_q;
   logic [7:0]                 req_addr_q;
   logic [31:0]                req_wdata_q;
   logic [7:0]                 busy_q, done_q, irq_en_q;
   logic [ADDR_WIDTH-1:0]      src_q [8];
   logic [ADDR_WIDTH-1:0]      dst_q [8];
   logic [ADDR_WIDTH-1:0]      wsrc_q [8];
   logic [ADDR_WIDTH-1:0]      wdst_q [8];
   logic [31:0]                len_q [8];
   logic [31:0]                wrem_q [8];
   logic [2:0]                 rr_q, gnt_q;
   logic [31:0]                beats_q;
   logic                       cmd_valid_q;
   logic [ADDR_WIDTH-1:0]      cmd_src_q, cmd_dst_q;
   logic [BURST_LEN_WIDTH-1:0] cmd_len_q;

   logic [2:0]  ch, idx, arb_ch;
   logic [3:0]  off;
   logic        chan_hit, wr_en, chan_wr, go, go_empty, fin;
   logic [7:0]  done_clr, done_set;
   logic [31:0] rdata, s_room, d_room, burst;

   assign ch       = req_addr_q[6:4];
   assign off      = req_addr_q[3:0];
   assign chan_hit = !req_addr_q[7] && ({29'd0, ch} < 32'(NUM_CH));
   assign wr_en    = req_q && req_wr_q;
   assign chan_wr  = wr_en && chan_hit && !busy_q[ch];
   assign go       = chan_wr && off == 4'h0 && req_wdata_q[0];
   assign go_empty = (len_q[ch] >> OFF) == 32'd0;
   assign fin      = state_q == WAIT && bus.cmd_done
                     && wrem_q[gnt_q] == beats_q;
   assign done_clr = (wr_en && req_addr_q == DONE_ADDR)
                     ? (req_wdata_q[7:0] & CH_MASK) : 8'd0;
   // a completing set is OR-ed in after the clear, so it wins
   assign done_set = ((go && go_empty) ? (8'd1 << ch) : 8'd0)
                     | (fin ? (8'd1 << gnt_q) : 8'd0);

   always_comb begin
      rdata = 32'd0;
      if (req_q) begin
         if (chan_hit) begin
            unique case (off)
               4'h0:    rdata = {30'd0, irq_en_q[ch], 1'b0};
               4'h4:    rdata = 32'(src_q[ch]);
               4'h8:    rdata = 32'(dst_q[ch]);
               4'hC:    rdata = len_q[ch];
               default: rdata = 32'd0;
            endcase
         end else if (req_addr_q == STATUS_ADDR) begin
            rdata = 32'(busy_q & CH_MASK);
         end else if (req_addr_q == DONE_ADDR) begin
            rdata = 32'(done_q & CH_MASK);
         end
      end
   end

   always_comb begin
      idx    = 3'd0;
      arb_ch = rr_q;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = 3'((int'(rr_q) + i) % NUM_CH);
         if (busy_q[idx]) arb_ch = idx;
      end
      s_room = (32'h1000 - {20'd0, wsrc_q[arb_ch][11:0]}) >> OFF;
      d_room = (32'h1000 - {20'd0, wdst_q[arb_ch][11:0]}) >> OFF;
      burst  = wrem_q[arb_ch];
      if (burst > 32'(MAX_BEATS)) burst = 32'(MAX_BEATS);
      if (burst > s_room) burst = s_room;
      if (burst > d_room) burst = d_room;
   end

   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         state_q     <= IDLE;
         req_q       <= 1'b0;
         req_wr_q    <= 1'b0;
         req_addr_q  <= 8'd0;
         req_wdata_q <= 32'd0;
         busy_q      <= 8'd0;
         done_q      <= 8'd0;
         irq_en_q    <= 8'd0;
         rr_q        <= 3'd0;
         gnt_q       <= 3'd0;
         beats_q     <= 32'd0;
         cmd_valid_q <= 1'b0;
         cmd_src_q   <= '0;
         cmd_dst_q   <= '0;
         cmd_len_q   <= '0;
         for (int c = 0; c < 8; c++) begin
            src_q[c]  <= '0;
            dst_q[c]  <= '0;
            wsrc_q[c] <= '0;
            wdst_q[c] <= '0;
            len_q[c]  <= 32'd0;
            wrem_q[c] <= 32'd0;
         end
      end else begin
         req_q <= bus.addr_valid;
         if (bus.addr_valid) begin
            req_wr_q    <= bus.reg_write;
            req_addr_q  <= bus.reg_addr[7:0];
            req_wdata_q <= bus.reg_wdata;
         end
         done_q <= (done_q & ~done_clr) | done_set;
         if (chan_wr) begin
            unique case (off)
               4'h0:    irq_en_q[ch] <= req_wdata_q[1];
               4'h4:    src_q[ch] <= ADDR_WIDTH'(req_wdata_q);
               4'h8:    dst_q[ch] <= ADDR_WIDTH'(req_wdata_q);
               4'hC:    len_q[ch] <= req_wdata_q;
               default: ;
            endcase
         end
         if (go && !go_empty) begin
            busy_q[ch] <= 1'b1;
            wsrc_q[ch] <= src_q[ch] & ALIGN;
            wdst_q[ch] <= dst_q[ch] & ALIGN;
            wrem_q[ch] <= len_q[ch] >> OFF;
         end
         unique case (state_q)
            IDLE: if (|busy_q) state_q <= ARB;
            ARB: begin
               gnt_q       <= arb_ch;
               rr_q        <= 3'((int'(arb_ch) + 1) % NUM_CH);
               beats_q     <= burst;
               cmd_src_q   <= wsrc_q[arb_ch];
               cmd_dst_q   <= wdst_q[arb_ch];
               cmd_len_q   <= BURST_LEN_WIDTH'(burst - 32'd1);
               cmd_valid_q <= 1'b1;
               state_q     <= ISSUE;
            end
            ISSUE: begin
               if (bus.cmd_ready) begin
                  cmd_valid_q <= 1'b0;
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               if (bus.cmd_done) begin
                  wsrc_q[gnt_q] <= wsrc_q[gnt_q] + ADDR_WIDTH'(beats_q << OFF);
                  wdst_q[gnt_q] <= wdst_q[gnt_q] + ADDR_WIDTH'(beats_q << OFF);
                  wrem_q[gnt_q] <= wrem_q[gnt_q] - beats_q;
                  if (fin) busy_q[gnt_q] <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.reg_ready = req_q;
   assign bus.reg_rdata = rdata;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_src   = cmd_src_q;
   assign bus.cmd_dst   = cmd_dst_q;
   assign bus.cmd_len   = cmd_len_q;
   assign bus.cmd_ch    = gnt_q;
   assign irq           = |(done_q & irq_en_q & CH_MASK);
endmodule

// File: tb/tb_soc_miner_dma_ctrl.sv
// tb_soc_miner_dma_ctrl: register vector table, command scoreboard
// and directed multi-cycle sequences for the copy engine.
module tb_soc_miner_dma_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic irq;
   logic auto_done = 1'b0;
   logic man_done = 1'b0;

   always #5 clk = ~clk;

   soc_miner_dma_ctrl_if #(.ADDR_WIDTH(32), .BURST_LEN_WIDTH(4)) bus();

   soc_miner_dma_ctrl #(
      .NUM_CH(4), .DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_LEN_WIDTH(4)
   ) dut (
      .Clk(clk), .RESET(rst), .bus(bus), .irq(irq)
   );

   assign bus.cmd_done = auto_done | man_done;

   typedef struct packed {
      logic [2:0]  ch;
      logic [31:0] src;
      logic [31:0] dst;
      logic [3:0]  len;
   } cmd_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } vec_t;

   cmd_t       exp_q[$];
   logic [2:0] ch_log[$];
   int         checks = 0;
   int         failures = 0;
   int         accepted = 0;
   int         valid_cycles = 0;
   bit         manual_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   always @(negedge clk) if (!rst && bus.cmd_valid) valid_cycles++;

   initial begin : responder
      cmd_t got;
      int   idx;
      forever begin
         @(negedge clk);
         if (!rst && bus.cmd_valid && bus.cmd_ready) begin
            got = {bus.cmd_ch, bus.cmd_src, bus.cmd_dst, bus.cmd_len};
            idx = -1;
            foreach (exp_q[i]) if (idx < 0 && exp_q[i].ch == got.ch) idx = i;
            checks++;
            if (idx < 0) begin
               failures++;
               $display("FAIL cmd_unexpected: ch=%0d src=0x%0h len=%0d, required none",
                        got.ch, got.src, got.len);
            end else begin
               if (exp_q[idx] != got) begin
                  failures++;
                  $display("FAIL cmd_fields: ch=%0d src=0x%0h dst=0x%0h len=%0d, required src=0x%0h dst=0x%0h len=%0d",
                           got.ch, got.src, got.dst, got.len,
                           exp_q[idx].src, exp_q[idx].dst, exp_q[idx].len);
               end
               exp_q.delete(idx);
            end
            ch_log.push_back(got.ch);
            accepted++;
            if (!manual_done) begin
               @(posedge clk);
               repeat (2) @(posedge clk);
               #1 auto_done = 1'b1;
               @(posedge clk);
               #1 auto_done = 1'b0;
            end
         end
      end
   end

   task automatic reg_acc(input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
      @(posedge clk);
      #1;
      bus.addr_valid = 1'b1;
      bus.reg_write  = wr;
      bus.reg_addr   = addr;
      bus.reg_wdata  = wdata;
      @(posedge clk);
      #1 bus.addr_valid = 1'b0;
      @(negedge clk);
      check("reg_ready", bus.reg_ready, 1);
      rdata = bus.reg_rdata;
      @(posedge clk);
      #1 check("reg_ready_pulse", bus.reg_ready, 0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] d;
      reg_acc(1'b1, addr, data, d);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] addr,
                         input logic [31:0] req);
      logic [31:0] d;
      reg_acc(1'b0, addr, 32'd0, d);
      check(name, d, req);
   endtask

   task automatic wait_idle(input string name);
      logic [31:0] s;
      int n;
      n = 0;
      do begin
         reg_acc(1'b0, 32'h40, 32'd0, s);
         n++;
      end while (s[3:0] != 4'd0 && n < 400);
      check({name, "_idle"}, s, 0);
      check({name, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic push_cmd(input logic [2:0] ch, input logic [31:0] s,
                           input logic [31:0] d, input logic [3:0] l);
      cmd_t e;
      e.ch = ch; e.src = s; e.dst = d; e.len = l;
      exp_q.push_back(e);
   endtask

   // reference job splitter: 8-byte beats, 16-beat cap, no 4 KiB crossing
   task automatic plan(input logic [2:0] ch, input logic [31:0] s,
                       input logic [31:0] d, input logic [31:0] l);
      int rem, b, sr, dr;
      logic [31:0] cs, cd;
      cs = s & ~32'h7;
      cd = d & ~32'h7;
      rem = int'(l / 8);
      while (rem > 0) begin
         sr = int'((4096 - (cs % 4096)) / 8);
         dr = int'((4096 - (cd % 4096)) / 8);
         b = rem;
         if (b > 16) b = 16;
         if (b > sr) b = sr;
         if (b > dr) b = dr;
         push_cmd(ch, cs, cd, 4'(b - 1));
         cs += 32'(b * 8);
         cd += 32'(b * 8);
         rem -= b;
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   vec_t vt[18];

   initial begin : main
      int n, n0, v0;
      rst = 1'b1;
      bus.addr_valid = 1'b0;
      bus.reg_write  = 1'b0;
      bus.reg_addr   = 32'd0;
      bus.reg_wdata  = 32'd0;
      bus.cmd_ready  = 1'b0;

      vt[0]  = '{1'b0, 32'h04, 32'h0};
      vt[1]  = '{1'b0, 32'h40, 32'h0};
      vt[2]  = '{1'b0, 32'h44, 32'h0};
      vt[3]  = '{1'b1, 32'h04, 32'h1234_5677};
      vt[4]  = '{1'b0, 32'h04, 32'h1234_5677};
      vt[5]  = '{1'b1, 32'h18, 32'hABCD_0008};
      vt[6]  = '{1'b0, 32'h18, 32'hABCD_0008};
      vt[7]  = '{1'b1, 32'h3C, 32'h55};
      vt[8]  = '{1'b0, 32'h3C, 32'h55};
      vt[9]  = '{1'b1, 32'h20, 32'h2};
      vt[10] = '{1'b0, 32'h20, 32'h2};
      vt[11] = '{1'b1, 32'h48, 32'hFFFF_FFFF};
      vt[12] = '{1'b0, 32'h48, 32'h0};
      vt[13] = '{1'b0, 32'h104, 32'h1234_5677};
      vt[14] = '{1'b1, 32'h40, 32'hF};
      vt[15] = '{1'b0, 32'h40, 32'h0};
      vt[16] = '{1'b1, 32'h20, 32'h0};
      vt[17] = '{1'b0, 32'h20, 32'h0};

      repeat (3) @(posedge clk);
      #1;
      check("rst_irq", irq, 0);
      check("rst_cmd_valid", bus.cmd_valid, 0);
      check("rst_reg_ready", bus.reg_ready, 0);
      check("rst_reg_rdata", bus.reg_rdata, 0);
      @(negedge clk) rst = 1'b0;

      foreach (vt[i]) begin
         if (vt[i].wr) wr(vt[i].addr, vt[i].data);
         else rd_chk($sformatf("vec%0d", i), vt[i].addr, vt[i].data);
      end

      bus.cmd_ready = 1'b1;
      wr(32'h04, 32'h1000);
      wr(32'h08, 32'h8000);
      wr(32'h0C, 32'h100);
      push_cmd(3'd0, 32'h1000, 32'h8000, 4'd15);
      push_cmd(3'd0, 32'h1080, 32'h8080, 4'd15);
      wr(32'h00, 32'h1);
      wait_idle("job_basic");
      rd_chk("basic_done", 32'h44, 32'h1);
      rd_chk("ctrl_go_reads0", 32'h00, 32'h0);
      check("basic_irq_masked", irq, 0);
      wr(32'h44, 32'h1);
      rd_chk("basic_w1c", 32'h44, 32'h0);

      wr(32'h04, 32'h0FF4);
      wr(32'h08, 32'h2000);
      wr(32'h0C, 32'h44);
      rd_chk("src_lowbits_kept", 32'h04, 32'h0FF4);
      push_cmd(3'd0, 32'h0FF0, 32'h2000, 4'd1);
      push_cmd(3'd0, 32'h1000, 32'h2010, 4'd5);
      wr(32'h00, 32'h1);
      wait_idle("job_4k");
      rd_chk("4k_done", 32'h44, 32'h1);
      wr(32'h44, 32'h1);

      wr(32'h14, 32'h10000);
      wr(32'h18, 32'h20000);
      wr(32'h1C, 32'h200);
      wr(32'h24, 32'h30000);
      wr(32'h28, 32'h40000);
      wr(32'h2C, 32'h200);
      ch_log.delete();
      plan(3'd1, 32'h10000, 32'h20000, 32'h200);
      plan(3'd2, 32'h30000, 32'h40000, 32'h200);
      wr(32'h10, 32'h1);
      wr(32'h20, 32'h1);
      wait_idle("job_rr");
      check("rr_count", ch_log.size(), 8);
      foreach (ch_log[i])
         check($sformatf("rr_ch%0d", i), ch_log[i], (i % 2 == 0) ? 1 : 2);
      rd_chk("rr_done", 32'h44, 32'h6);
      wr(32'h44, 32'h6);

      wr(32'h34, 32'h0);
      wr(32'h38, 32'h100);
      wr(32'h3C, 32'h40);
      plan(3'd3, 32'h0, 32'h100, 32'h40);
      wr(32'h30, 32'h3);
      wait_idle("job_irq");
      check("irq_set", irq, 1);
      rd_chk("irq_en_rb", 32'h30, 32'h2);
      wr(32'h44, 32'h8);
      check("irq_w1c", irq, 0);

      manual_done = 1'b1;
      wr(32'h34, 32'h200);
      wr(32'h38, 32'h300);
      plan(3'd3, 32'h200, 32'h300, 32'h40);
      wr(32'h30, 32'h3);
      n0 = accepted;
      n = 0;
      while (accepted == n0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("coincide_accept", accepted != n0, 1);
      @(posedge clk);
      #1;
      bus.addr_valid = 1'b1;
      bus.reg_write  = 1'b1;
      bus.reg_addr   = 32'h44;
      bus.reg_wdata  = 32'h8;
      @(posedge clk);
      #1;
      bus.addr_valid = 1'b0;
      man_done = 1'b1;
      @(posedge clk);
      #1 man_done = 1'b0;
      rd_chk("set_beats_w1c", 32'h44, 32'h8);
      rd_chk("coincide_status", 32'h40, 32'h0);
      check("coincide_irq", irq, 1);
      manual_done = 1'b0;
      wr(32'h44, 32'h8);
      wr(32'h30, 32'h0);

      wr(32'h1C, 32'h4);
      v0 = valid_cycles;
      wr(32'h10, 32'h1);
      repeat (10) @(negedge clk);
      check("short_no_cmd", valid_cycles, v0);
      rd_chk("short_done", 32'h44, 32'h2);
      rd_chk("short_status", 32'h40, 32'h0);
      wr(32'h44, 32'h2);

      bus.cmd_ready = 1'b0;
      wr(32'h04, 32'h5000);
      wr(32'h08, 32'h6000);
      wr(32'h0C, 32'h100);
      wr(32'h00, 32'h1);
      repeat (5) @(negedge clk);
      rd_chk("stall_status", 32'h40, 32'h1);
      wr(32'h0C, 32'h999);
      rd_chk("busy_len_locked", 32'h0C, 32'h100);
      wr(32'h04, 32'h7);
      rd_chk("busy_src_locked", 32'h04, 32'h5000);
      @(posedge clk);
      #1 man_done = 1'b1;
      @(posedge clk);
      #1 man_done = 1'b0;
      rd_chk("stray_done_ignored", 32'h40, 32'h1);
      @(negedge clk);
      check("stall_valid", bus.cmd_valid, 1);
      check("stall_src", bus.cmd_src, 32'h5000);
      repeat (3) @(negedge clk);
      check("stable_src", bus.cmd_src, 32'h5000);
      check("stable_dst", bus.cmd_dst, 32'h6000);
      check("stable_len", bus.cmd_len, 15);
      check("stable_ch", bus.cmd_ch, 0);

      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst_async_valid", bus.cmd_valid, 0);
      check("rst_async_irq", irq, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      bus.cmd_ready = 1'b1;
      rd_chk("post_rst_status", 32'h40, 32'h0);
      rd_chk("post_rst_done", 32'h44, 32'h0);
      rd_chk("post_rst_src0", 32'h04, 32'h0);
      rd_chk("post_rst_len0", 32'h0C, 32'h0);
      rd_chk("post_rst_dst1", 32'h18, 32'h0);
      v0 = valid_cycles;
      repeat (10) @(negedge clk);
      check("post_rst_no_cmd", valid_cycles, v0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
